// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the master and its testbench.
package ahb_pkg;

  // Transfer types; this master only ever issues single NONSEQ transfers.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // All transfers are 32-bit words.
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Slave response encodings.
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage : ahb_pkg

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master with a two-stage (address / data) pipeline.
// A command enters the address slot, moves to the data slot when the bus
// advances, and produces a one-cycle response pulse when its data phase ends.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  // AHB-Lite bus
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  // Address slot
  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] haddr_q,   haddr_d;
  logic              hwrite_q,  hwrite_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  // Data slot
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] hwdata_q,  hwdata_d;
  // Response register
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic accept;
  logic a_adv;
  logic d_done;

  // Byte-lane bits of the command address are ignored for word transfers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[1:0];

  // A new command fits if the address slot is empty or is leaving this cycle.
  assign cmd_ready = !a_valid_q || HREADY;
  assign accept    = cmd_valid && cmd_ready;
  assign a_adv     = a_valid_q && HREADY;
  assign d_done    = d_valid_q && HREADY;

  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  // Next-state for both pipeline slots and the response; completion, advance
  // and accept are evaluated in pipeline order so all three can coincide.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    a_valid_d   = a_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;

    // Data phase ends: report it and empty the data slot.
    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = (HRESP == HRESP_ERROR);
      if (!d_write_q) begin
        rsp_rdata_d = HRDATA;
      end
      d_valid_d = 1'b0;
      d_write_d = 1'b0;
      hwdata_d  = '0;
    end

    // Address phase ends: the transfer becomes the new data phase.
    if (a_adv) begin
      a_valid_d = 1'b0;
      d_valid_d = 1'b1;
      d_write_d = hwrite_q;
      hwdata_d  = hwrite_q ? a_wdata_q : '0;
    end

    // New command refills the address slot (wins over the clear above).
    if (accept) begin
      a_valid_d = 1'b1;
      haddr_d   = {cmd_addr[ADDR_W-1:2], 2'b00};
      hwrite_d  = cmd_write;
      a_wdata_d = cmd_write ? cmd_wdata : '0;
    end
  end

  // Pipeline and response registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      a_valid_q   <= a_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule : ahb_lite_master

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master. The bench acts as the AHB slave and
// keeps a transaction-level model: queues of transfers in the address and data
// phases, plus the response expected after each completed data phase.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        a_q[$];
  txn_t        d_q[$];
  logic        exp_rsp_v;
  logic [31:0] exp_rsp_rd;
  logic        exp_rsp_err;
  int          n_checks;
  int          n_errors;
  int          n_rsp_exp;
  int          n_rsp_seen;
  logic        err_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: called at a falling edge, drives inputs, checks outputs,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic step(input logic cv, input logic cw, input logic [31:0] ca,
                      input logic [31:0] cd, input logic hr, input logic hresp,
                      input logic [31:0] hrd);
    logic exp_ready;
    txn_t t;
    cmd_valid = cv;
    cmd_write = cw;
    cmd_addr  = ca;
    cmd_wdata = cd;
    HREADY    = hr;
    HRESP     = hresp;
    HRDATA    = hrd;
    #1;
    exp_ready = (a_q.size() == 0) || hr;
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
    check("htrans", {30'd0, HTRANS}, {30'd0, (a_q.size() != 0) ? HTRANS_NONSEQ : HTRANS_IDLE});
    check("hsize", {29'd0, HSIZE}, {29'd0, HSIZE_WORD});
    if (a_q.size() != 0) begin
      check("haddr", HADDR, a_q[0].addr);
      check("hwrite", {31'd0, HWRITE}, {31'd0, a_q[0].wr});
    end
    check("hwdata", HWDATA, (d_q.size() != 0 && d_q[0].wr) ? d_q[0].wdata : 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_v});
    if (rsp_valid) n_rsp_seen++;
    if (exp_rsp_v) begin
      check("rsp_rdata", rsp_rdata, exp_rsp_rd);
      check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_rsp_err});
    end
    // Model update for the coming rising edge.
    exp_rsp_v = 1'b0;
    if (d_q.size() != 0 && hr) begin
      t           = d_q.pop_front();
      exp_rsp_v   = 1'b1;
      exp_rsp_err = (hresp == HRESP_ERROR);
      exp_rsp_rd  = t.wr ? 32'd0 : hrd;
      n_rsp_exp++;
    end
    if (a_q.size() != 0 && hr) begin
      d_q.push_back(a_q.pop_front());
    end
    if (cv && exp_ready) begin
      t.wr    = cw;
      t.addr  = ca & 32'hFFFF_FFFC;
      t.wdata = cd;
      a_q.push_back(t);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
  endtask

  // With reset held, every output must be at its cleared value.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"},  {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
    check({tag, "_haddr"},   HADDR, 32'd0);
    check({tag, "_hwrite"},  {31'd0, HWRITE}, 32'd0);
    check({tag, "_hwdata"},  HWDATA, 32'd0);
    check({tag, "_rsp_v"},   {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rd"},  rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_error}, 32'd0);
  endtask

  initial begin
    logic        cv, cw, hr, hresp;
    logic [31:0] ca, cd, hrd;
    n_checks   = 0;
    n_errors   = 0;
    n_rsp_exp  = 0;
    n_rsp_seen = 0;
    exp_rsp_v  = 1'b0;
    exp_rsp_rd = 32'd0;
    exp_rsp_err = 1'b0;
    err_pend   = 1'b0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 32'd0;
    cmd_wdata  = 32'd0;
    HRDATA     = 32'd0;
    HREADY     = 1'b1;
    HRESP      = HRESP_OKAY;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Single zero-wait write to 0x10.
    step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, HRESP_OKAY, 32'd0);
    check("w10_htrans", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    check("w10_haddr", HADDR, 32'h10);
    check("w10_hwrite", {31'd0, HWRITE}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    check("w10_hwdata", HWDATA, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    check("w10_rsp_v", {31'd0, rsp_valid}, 32'd1);
    check("w10_rsp_err", {31'd0, rsp_error}, 32'd0);
    idle(1);

    // Read 0x14 with three data-phase wait states.
    step(1'b1, 1'b0, 32'h14, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, HRESP_OKAY, 32'hBAD0_0000);
      check("r14_hwdata", HWDATA, 32'd0);
    end
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'h1234_5678);
    check("r14_rsp_v", {31'd0, rsp_valid}, 32'd1);
    check("r14_rdata", rsp_rdata, 32'h1234_5678);
    idle(1);

    // Four back-to-back zero-wait writes 0x00..0x0C.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, HRESP_OKAY, 32'd0);
    end
    idle(4);

    // Read 0x20 with two-cycle ERROR while write 0x24 waits in the address phase.
    step(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    step(1'b1, 1'b1, 32'h24, 32'h2424_2424, 1'b1, HRESP_OKAY, 32'd0);
    step(1'b1, 1'b1, 32'h28, 32'h2828_2828, 1'b0, HRESP_ERROR, 32'd0);
    check("e20_haddr_hold", HADDR, 32'h24);
    check("e20_htrans_hold", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_ERROR, 32'd0);
    check("e20_rsp_err", {31'd0, rsp_error}, 32'd1);
    idle(3);

    // Reset asserted during the data phase of a read.
    step(1'b1, 1'b0, 32'h30, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, HRESP_OKAY, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, HRESP_OKAY, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    a_q.delete();
    d_q.delete();
    exp_rsp_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic with wait states and two-cycle error responses.
    for (int i = 0; i < 600; i++) begin
      cv  = ($urandom_range(0, 3) != 0);
      cw  = 1'($urandom_range(0, 1));
      ca  = $urandom();
      cd  = $urandom();
      hrd = $urandom();
      if (err_pend) begin
        hr = 1'b1; hresp = HRESP_ERROR; err_pend = 1'b0;
      end else if (d_q.size() != 0 && $urandom_range(0, 7) == 0) begin
        hr = 1'b0; hresp = HRESP_ERROR; err_pend = 1'b1;
      end else begin
        hresp = HRESP_OKAY;
        hr = (d_q.size() == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      step(cv, cw, ca, cd, hr, hresp, hrd);
    end
    idle(4);

    check("queues_drained", 32'(a_q.size() + d_q.size()), 32'd0);
    check("rsp_count", 32'(n_rsp_seen), 32'(n_rsp_exp));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ahb_lite_master
